instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter INSTRUCTION_LENGTH, default 16, instruction word width.
REQ-002 The block SHALL have parameter ADDRESS_WIDTH, default 8, program address width (matches the 8-bit memory/immediate field).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports clock (input, 1, rising-edge clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-004 The block SHALL have port mem_req, output, 1 bit: read request to instruction memory.
REQ-005 The block SHALL have port mem_address, output, ADDRESS_WIDTH bits: read address, equal to pc.
REQ-006 The block SHALL have port mem_ready, input, 1 bit: memory data valid this cycle.
REQ-007 The block SHALL have port mem_rdata, input, INSTRUCTION_LENGTH bits: memory read data.
REQ-008 The block SHALL have port instruction, output, INSTRUCTION_LENGTH bits: registered word to instruction_decoder.
REQ-009 The block SHALL have port instruction_valid, output, 1 bit: instruction holds a valid word.
REQ-010 The block SHALL have port decode_ready, input, 1 bit: downstream accepts instruction this cycle.
REQ-011 The block SHALL have port redirect, input, 1 bit: load redirect_address into pc (jump/branch).
REQ-012 The block SHALL have port redirect_address, input, ADDRESS_WIDTH bits: redirect target.
REQ-013 The block SHALL have port halt, input, 1 bit: level-sensitive fetch stop.
REQ-014 The block SHALL have port pc, output, ADDRESS_WIDTH bits: address of the word being fetched or held.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, HOLD and HALTED; all outputs SHALL be registered or decoded from state only, with no combinational input-to-output path.
REQ-016 IDLE SHALL go to HALTED on the first rising edge after reset release if halt=1, else to FETCH.
REQ-017 FETCH SHALL drive mem_req=1 with mem_address=pc stable until a cycle with mem_ready=1.
REQ-018 FETCH SHALL, on that edge, capture mem_rdata into instruction, set instruction_valid=1 and go to HOLD.
REQ-019 HOLD SHALL keep instruction and instruction_valid stable until decode_ready=1.
REQ-020 HOLD SHALL, on the decode_ready edge, clear instruction_valid and set pc=pc+1, going to HALTED if halt=1, else FETCH.
REQ-021 Latency SHALL be: with mem_ready tied 1, instruction_valid rises 1 cycle after FETCH entry; sustained throughput is 1 word per 2 cycles.
REQ-022 pc increment SHALL be modulo 2^ADDRESS_WIDTH (8'hFF+1 = 8'h00), with no flag.
REQ-023 redirect=1 in any non-IDLE state SHALL load pc=redirect_address on that edge.
REQ-024 redirect=1 SHALL discard any word returned in that cycle and any held word (instruction_valid=0 next cycle).
REQ-025 After a redirect, the next state SHALL be FETCH, or HALTED if halt=1.
REQ-026 redirect SHALL take priority over mem_ready, decode_ready and the pc increment in the same cycle.
REQ-027 HALTED SHALL drive mem_req=0 and instruction_valid=0.
REQ-028 HALTED SHALL go to FETCH at the current pc when halt=0.
REQ-029 halt asserted during FETCH or HOLD SHALL take effect only at the next FETCH entry; an outstanding request completes first.

Reset
REQ-030 reset_n=0 SHALL asynchronously force state=IDLE, pc=0, instruction=0, instruction_valid=0 and mem_req=0.
REQ-031 Reset asserted mid-fetch or mid-hold SHALL abandon the transaction; after release, fetching SHALL restart at address 0.

Structure
REQ-032 INSTRUCTION_LENGTH, ADDRESS_WIDTH and the 2-bit state encoding (IDLE=0, FETCH=1, HOLD=2, HALTED=3) SHALL be defined in shared package cpu_pkg.
REQ-033 pc load/increment logic SHALL live in sub-module program_counter (inputs: load, increment, load_value; output: pc).
REQ-034 instruction SHALL connect directly to instruction_decoder.instruction.

Verification
REQ-035 The bench SHALL check: reset release, mem_ready=1, decode_ready=1, memory[a]=16'hA000+a -> words 16'hA000, 16'hA001, 16'hA002 presented at pc 0,1,2, one every 2 cycles.
REQ-036 The bench SHALL check: mem_ready held 0 for 3 cycles at pc=5 -> mem_req=1 and mem_address=8'h05 stable all 3 cycles; instruction_valid rises on the edge after mem_ready=1.
REQ-037 The bench SHALL check: decode_ready=0 for 4 cycles in HOLD -> instruction unchanged, mem_req=0, pc unchanged throughout.
REQ-038 The bench SHALL check: redirect=1, redirect_address=8'h40 in the same cycle as mem_ready=1 at pc=3 -> returned word dropped, next mem_address=8'h40, next presented word is memory[8'h40].
REQ-039 The bench SHALL check: pc=8'hFF accepted -> next mem_address=8'h00.
REQ-040 The bench SHALL check: halt=1 during HOLD at pc=7 -> after accept, HALTED with mem_req=0; halt=0 -> fetch resumes at 8'h08; reset_n pulsed mid-FETCH -> all outputs 0 immediately, restart at 8'h00.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths and fetch state encoding for the cpu slice
//   INSTRUCTION_LENGTH : default instruction word width
//   ADDRESS_WIDTH      : default program address width
//   fetch_state_t      : fetch FSM encoding (IDLE=0, FETCH=1, HOLD=2, HALTED=3)
package cpu_pkg;

    localparam int INSTRUCTION_LENGTH = 16;
    localparam int ADDRESS_WIDTH      = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_counter.sv
// rtl/program_counter.sv - program counter register with load and wrapping increment
//   clock, reset_n : rising-edge clock, asynchronous active-low reset (pc -> 0)
//   load           : load load_value into pc (wins over increment)
//   increment      : pc <= pc + 1, modulo 2^ADDRESS_WIDTH
//   load_value     : redirect target
//   pc             : current program counter
module program_counter #(
    parameter int ADDRESS_WIDTH = cpu_pkg::ADDRESS_WIDTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     load,
    input  logic                     increment,
    input  logic [ADDRESS_WIDTH-1:0] load_value,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    logic [ADDRESS_WIDTH-1:0] pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_value;
        end else if (increment) begin
            // Natural overflow gives the wrap from all-ones back to zero.
            pc_d = pc_q + ADDRESS_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch stage: memory request, word hold, redirect and halt
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   mem_req/mem_address : read request to instruction memory (address is pc)
//   mem_ready/mem_rdata : memory data valid / read data
//   instruction(_valid) : registered word presented to instruction_decoder
//   decode_ready        : decoder accepts the held word this cycle
//   redirect(_address)  : jump/branch target load into pc
//   halt                : level-sensitive fetch stop
//   pc                  : address of the word being fetched or held
module instruction_fetch #(
    parameter int INSTRUCTION_LENGTH = cpu_pkg::INSTRUCTION_LENGTH,
    parameter int ADDRESS_WIDTH      = cpu_pkg::ADDRESS_WIDTH
) (
    input  logic                          clock,
    input  logic                          reset_n,
    output logic                          mem_req,
    output logic [ADDRESS_WIDTH-1:0]      mem_address,
    input  logic                          mem_ready,
    input  logic [INSTRUCTION_LENGTH-1:0] mem_rdata,
    output logic [INSTRUCTION_LENGTH-1:0] instruction,
    output logic                          instruction_valid,
    input  logic                          decode_ready,
    input  logic                          redirect,
    input  logic [ADDRESS_WIDTH-1:0]      redirect_address,
    input  logic                          halt,
    output logic [ADDRESS_WIDTH-1:0]      pc
);

    import cpu_pkg::*;

    fetch_state_t                  state_q;
    fetch_state_t                  state_d;
    logic [INSTRUCTION_LENGTH-1:0] instruction_q;
    logic [INSTRUCTION_LENGTH-1:0] instruction_d;
    logic                          instruction_valid_q;
    logic                          instruction_valid_d;
    logic                          pc_load;
    logic                          pc_increment;
    logic [ADDRESS_WIDTH-1:0]      pc_value;

    program_counter #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_program_counter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (pc_load),
        .increment  (pc_increment),
        .load_value (redirect_address),
        .pc         (pc_value)
    );

    always_comb begin
        state_d             = state_q;
        instruction_d       = instruction_q;
        instruction_valid_d = instruction_valid_q;
        pc_load             = 1'b0;
        pc_increment        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = halt ? HALTED : FETCH;
            end
            FETCH: begin
                // halt is deliberately ignored here: the outstanding read
                // completes and halt is honoured on the way back to FETCH.
                if (mem_ready) begin
                    instruction_d       = mem_rdata;
                    instruction_valid_d = 1'b1;
                    state_d             = HOLD;
                end
            end
            HOLD: begin
                if (decode_ready) begin
                    instruction_valid_d = 1'b0;
                    pc_increment        = 1'b1;
                    state_d             = halt ? HALTED : FETCH;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A redirect overrides everything above: the returned or held word
        // is dropped and pc takes the target instead of incrementing.
        if (redirect && (state_q != IDLE)) begin
            instruction_d       = instruction_q;
            instruction_valid_d = 1'b0;
            pc_load             = 1'b1;
            pc_increment        = 1'b0;
            state_d             = halt ? HALTED : FETCH;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q             <= IDLE;
            instruction_q       <= '0;
            instruction_valid_q <= 1'b0;
        end else begin
            state_q             <= state_d;
            instruction_q       <= instruction_d;
            instruction_valid_q <= instruction_valid_d;
        end
    end

    // mem_req is decoded from state alone so no input reaches an output
    // combinationally.
    assign mem_req           = (state_q == FETCH);
    assign mem_address       = pc_value;
    assign pc                = pc_value;
    assign instruction       = instruction_q;
    assign instruction_valid = instruction_valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard testbench for instruction_fetch
module tb_instruction_fetch;

    typedef struct packed {
        logic [15:0] word;
        logic [7:0]  pc;
    } exp_t;

    logic        clock;
    logic        reset_n;
    logic        mem_req;
    logic [7:0]  mem_address;
    logic        mem_ready;
    logic [15:0] mem_rdata;
    logic [15:0] instruction;
    logic        instruction_valid;
    logic        decode_ready;
    logic        redirect;
    logic [7:0]  redirect_address;
    logic        halt;
    logic [7:0]  pc;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    instruction_fetch #(
        .INSTRUCTION_LENGTH (16),
        .ADDRESS_WIDTH      (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .mem_req           (mem_req),
        .mem_address       (mem_address),
        .mem_ready         (mem_ready),
        .mem_rdata         (mem_rdata),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .decode_ready      (decode_ready),
        .redirect          (redirect),
        .redirect_address  (redirect_address),
        .halt              (halt),
        .pc                (pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory model: memory[a] = 16'hA000 + a
    always_comb mem_rdata = 16'hA000 + {8'h00, mem_address};

    task automatic do_reset(input logic mr, input logic dr, input logic h);
        @(negedge clock);
        reset_n          = 1'b0;
        redirect         = 1'b0;
        redirect_address = 8'h00;
        mem_ready        = mr;
        decode_ready     = dr;
        halt             = h;
        exp_q.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clock);
            if (instruction_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1, 1'b1, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        total++; if (pc !== 8'h00) begin bad++; $display("FAIL reset_pc: got %h want 00", pc); end
        total++; if (mem_address !== 8'h00) begin bad++; $display("FAIL reset_addr: got %h want 00", mem_address); end
        total++; if (instruction !== 16'h0000) begin bad++; $display("FAIL reset_instr: got %h want 0000", instruction); end
        total++; if (instruction_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", instruction_valid); end
        // Leaving reset with halt=1 must park in HALTED.
        do_reset(1'b1, 1'b1, 1'b1);
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL idle_halt_req: got %b want 0", mem_req); end
        halt = 1'b0;
        @(negedge clock);
        total++; if (mem_req !== 1'b1 || mem_address !== 8'h00) begin bad++; $display("FAIL idle_halt_resume: got req=%b addr=%h want req=1 addr=00", mem_req, mem_address); end
    endtask

    task automatic test_stream();
        exp_t e;
        int   seen = 0;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) exp_q.push_back('{word: 16'hA000 + 16'(i), pc: 8'(i)});
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            total++;
            if (instruction_valid !== 1'((cyc % 2) == 0)) begin
                bad++; $display("FAIL stream_valid_cyc%0d: got %b want %b", cyc, instruction_valid, 1'((cyc % 2) == 0));
            end
            if (instruction_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (instruction !== e.word) begin bad++; $display("FAIL stream_word: got %h want %h", instruction, e.word); end
                total++; if (pc !== e.pc) begin bad++; $display("FAIL stream_pc: got %h want %h", pc, e.pc); end
                seen++;
            end
        end
        total++; if (seen != 3) begin bad++; $display("FAIL stream_count: got %0d want 3", seen); end
    endtask

    task automatic test_stall();
        exp_t e;
        do_reset(1'b0, 1'b1, 1'b0);
        @(negedge clock);
        redirect = 1'b1; redirect_address = 8'h05;
        @(negedge clock);
        redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mem_req !== 1'b1 || mem_address !== 8'h05 || instruction_valid !== 1'b0) begin
                bad++; $display("FAIL stall_cyc%0d: got req=%b addr=%h valid=%b want req=1 addr=05 valid=0", i, mem_req, mem_address, instruction_valid);
            end
            @(negedge clock);
        end
        mem_ready = 1'b1;
        exp_q.push_back('{word: 16'hA005, pc: 8'h05});
        @(negedge clock);
        total++;
        if (instruction_valid !== 1'b1) begin
            bad++; $display("FAIL stall_latency: got valid=%b want 1", instruction_valid);
        end else begin
            e = exp_q.pop_front();
            total++; if (instruction !== e.word) begin bad++; $display("FAIL stall_word: got %h want %h", instruction, e.word); end
            total++; if (pc !== e.pc) begin bad++; $display("FAIL stall_pc: got %h want %h", pc, e.pc); end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        bit   ok;
        do_reset(1'b1, 1'b0, 1'b0);
        exp_q.push_back('{word: 16'hA000, pc: 8'h00});
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL hold_timeout: instruction_valid never rose");
        end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 4; i++) begin
                @(negedge clock);
                total++;
                if (instruction !== e.word || instruction_valid !== 1'b1 || mem_req !== 1'b0 || pc !== e.pc) begin
                    bad++; $display("FAIL hold_cyc%0d: got instr=%h valid=%b req=%b pc=%h want instr=%h valid=1 req=0 pc=%h",
                                    i, instruction, instruction_valid, mem_req, pc, e.word, e.pc);
                end
            end
            decode_ready = 1'b1;
            @(negedge clock);
            total++;
            if (instruction_valid !== 1'b0 || pc !== 8'h01 || mem_req !== 1'b1) begin
                bad++; $display("FAIL hold_accept: got valid=%b pc=%h req=%b want valid=0 pc=01 req=1", instruction_valid, pc, mem_req);
            end
        end
    endtask

    task automatic test_redirect();
        exp_t e;
        bit   ok;
        bit   found = 1'b0;
        do_reset(1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (mem_req === 1'b1 && mem_address === 8'h03) begin
                found = 1'b1;
                break;
            end
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL redirect_reach_pc3: fetch of 03 never seen");
        end else begin
            redirect = 1'b1; redirect_address = 8'h40;
            exp_q.push_back('{word: 16'hA040, pc: 8'h40});
            @(negedge clock);
            redirect = 1'b0;
            total++;
            if (instruction_valid !== 1'b0 || mem_address !== 8'h40 || mem_req !== 1'b1) begin
                bad++; $display("FAIL redirect_drop: got valid=%b addr=%h req=%b want valid=0 addr=40 req=1", instruction_valid, mem_address, mem_req);
            end
            wait_valid(ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL redirect_timeout: instruction_valid never rose");
            end else begin
                e = exp_q.pop_front();
                total++; if (instruction !== e.word) begin bad++; $display("FAIL redirect_word: got %h want %h", instruction, e.word); end
                total++; if (pc !== e.pc) begin bad++; $display("FAIL redirect_pc: got %h want %h", pc, e.pc); end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   ok;
        do_reset(1'b0, 1'b1, 1'b0);
        @(negedge clock);
        redirect = 1'b1; redirect_address = 8'hFF;
        @(negedge clock);
        redirect = 1'b0; mem_ready = 1'b1;
        exp_q.push_back('{word: 16'hA0FF, pc: 8'hFF});
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL wrap_timeout: instruction_valid never rose");
        end else begin
            e = exp_q.pop_front();
            total++; if (instruction !== e.word || pc !== e.pc) begin bad++; $display("FAIL wrap_word: got %h@%h want %h@%h", instruction, pc, e.word, e.pc); end
            @(negedge clock);
            total++;
            if (mem_address !== 8'h00 || mem_req !== 1'b1) begin
                bad++; $display("FAIL wrap_addr: got addr=%h req=%b want addr=00 req=1", mem_address, mem_req);
            end
        end
    endtask

    task automatic test_halt_and_reset();
        exp_t e;
        bit   ok;
        do_reset(1'b0, 1'b0, 1'b0);
        @(negedge clock);
        redirect = 1'b1; redirect_address = 8'h07;
        @(negedge clock);
        redirect = 1'b0; mem_ready = 1'b1;
        exp_q.push_back('{word: 16'hA007, pc: 8'h07});
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL halt_timeout: instruction_valid never rose");
            return;
        end
        e = exp_q.pop_front();
        total++; if (instruction !== e.word || pc !== e.pc) begin bad++; $display("FAIL halt_word: got %h@%h want %h@%h", instruction, pc, e.word, e.pc); end
        halt = 1'b1;
        @(negedge clock);
        total++; if (instruction_valid !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL halt_in_hold: got valid=%b req=%b want valid=1 req=0", instruction_valid, mem_req); end
        decode_ready = 1'b1;
        @(negedge clock);
        total++; if (mem_req !== 1'b0 || instruction_valid !== 1'b0 || pc !== 8'h08) begin bad++; $display("FAIL halted_state: got req=%b valid=%b pc=%h want req=0 valid=0 pc=08", mem_req, instruction_valid, pc); end
        @(negedge clock);
        total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL halted_stay: got req=%b want 0", mem_req); end
        halt = 1'b0;
        @(negedge clock);
        total++; if (mem_req !== 1'b1 || mem_address !== 8'h08) begin bad++; $display("FAIL halt_resume: got req=%b addr=%h want req=1 addr=08", mem_req, mem_address); end
        exp_q.push_back('{word: 16'hA008, pc: 8'h08});
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL resume_timeout: instruction_valid never rose");
        end else begin
            e = exp_q.pop_front();
            total++; if (instruction !== e.word || pc !== e.pc) begin bad++; $display("FAIL resume_word: got %h@%h want %h@%h", instruction, pc, e.word, e.pc); end
        end
        mem_ready = 1'b0;
        @(negedge clock);
        total++; if (mem_req !== 1'b1 || mem_address !== 8'h09) begin bad++; $display("FAIL midfetch_pre: got req=%b addr=%h want req=1 addr=09", mem_req, mem_address); end
        // Reset lands between edges: outputs must clear before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || pc !== 8'h00 || mem_address !== 8'h00 || instruction !== 16'h0000 || instruction_valid !== 1'b0) begin
            bad++; $display("FAIL async_reset: got req=%b pc=%h addr=%h instr=%h valid=%b want all 0",
                            mem_req, pc, mem_address, instruction, instruction_valid);
        end
        @(negedge clock);
        mem_ready = 1'b1; decode_ready = 1'b1; reset_n = 1'b1;
        exp_q.push_back('{word: 16'hA000, pc: 8'h00});
        wait_valid(ok);
        total++;
        if (!ok) begin
            bad++; $display("FAIL restart_timeout: instruction_valid never rose");
        end else begin
            e = exp_q.pop_front();
            total++; if (instruction !== e.word || pc !== e.pc) begin bad++; $display("FAIL restart_word: got %h@%h want %h@%h", instruction, pc, e.word, e.pc); end
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        mem_ready        = 1'b0;
        decode_ready     = 1'b0;
        redirect         = 1'b0;
        redirect_address = 8'h00;
        halt             = 1'b0;
        test_reset();
        test_stream();
        test_stall();
        test_hold();
        test_redirect();
        test_wrap();
        test_halt_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
